// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-bounded arbiter sharing one FIFO write port
//
// Ports:
//   i_clk        clock, all state on the rising edge
//   i_rst        asynchronous active-high reset
//   i_valid      per-requester beat available
//   i_data       per-requester data, requester k in [k*DATA_WIDTH +: DATA_WIDTH]
//   i_full       FIFO full flag
//   i_abort      synchronous abort of the current grant
//   o_ready      per-requester beat accepted this cycle
//   o_wr_en      FIFO write enable
//   o_data       FIFO write data
//   o_grant_vld  a grant is held
//   o_grant_id   index of the granted requester
`timescale 1ns/1ps
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_REQ-1:0]              i_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   i_data,
    input  logic                          i_full,
    input  logic                          i_abort,
    output logic [N_REQ-1:0]              o_ready,
    output logic                          o_wr_en,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_grant_vld,
    output logic [$clog2(N_REQ)-1:0]      o_grant_id
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;

    logic              arb_hit;
    logic [ID_W-1:0]   arb_id;
    logic              beat;
    logic              release_grant;
    logic [ID_W-1:0]   rr_next;

    // Scan from the highest offset down so the last hit written is the
    // requester closest to rr_ptr.
    always_comb begin
        logic [ID_W-1:0] idx;
        arb_hit = 1'b0;
        arb_id  = '0;
        idx     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
            if (i_valid[idx]) begin
                arb_hit = 1'b1;
                arb_id  = idx;
            end
        end
    end

    assign rr_next = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);

    // Datapath: a beat only happens while a grant is held.
    always_comb begin
        beat    = (state_q == BURST) && i_valid[grant_id_q] && !i_full && !i_abort;
        o_wr_en = beat;
        o_ready = '0;
        o_data  = '0;
        if (beat) begin
            o_ready[grant_id_q] = 1'b1;
            o_data              = i_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Release on burst limit, idle requester, or abort. Full alone keeps
    // the grant and does not consume burst budget.
    assign release_grant = (beat && (beat_cnt_q == CNT_W'(MAX_BURST - 1)))
                         || !i_valid[grant_id_q]
                         || i_abort;

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (!i_abort && arb_hit) begin
                    grant_id_d = arb_id;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if (release_grant) begin
                    state_d    = IDLE;
                    rr_ptr_d   = rr_next;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign o_grant_vld = (state_q == BURST);
    assign o_grant_id  = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard testbench for fifo_wr_arbiter
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_valid;
    logic [N*DW-1:0] i_data;
    logic            i_full;
    logic            i_abort;
    logic [N-1:0]    o_ready;
    logic            o_wr_en;
    logic [DW-1:0]   o_data;
    logic            o_grant_vld;
    logic [1:0]      o_grant_id;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .i_full(i_full), .i_abort(i_abort), .o_ready(o_ready), .o_wr_en(o_wr_en),
        .o_data(o_data), .o_grant_vld(o_grant_vld), .o_grant_id(o_grant_id)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  id;
        logic [7:0]  data;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] glog[$];
    int         cnt [N];
    int         vectors = 0;
    int         miscompares = 0;

    logic       s_wr_en, s_gv, prev_gv;
    logic [1:0] s_gid;
    logic [N-1:0] s_ready;

    task automatic drive_data();
        for (int k = 0; k < N; k++) i_data[k*DW +: DW] = 8'((k + 1) * 16 + cnt[k]);
    endtask

    task automatic clear_tb();
        for (int k = 0; k < N; k++) cnt[k] = 0;
        exp_q.delete();
        glog.delete();
        prev_gv = 1'b0;
        drive_data();
    endtask

    task automatic reset_dut();
        i_rst   = 1'b1;
        i_abort = 1'b0;
        i_full  = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    task automatic push_exp(input int id, input int first, input int n);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            e.id   = 2'(id);
            e.data = 8'(first + j);
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: sample/score at the falling edge, advance producers after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge i_clk);
        s_wr_en = o_wr_en;
        s_gv    = o_grant_vld;
        s_gid   = o_grant_id;
        s_ready = o_ready;
        vectors++;
        if (o_wr_en) begin
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got data=%h ready=%b, required no write", o_data, o_ready);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e.data || o_ready !== (4'b0001 << e.id) || o_grant_id !== e.id) begin
                    miscompares++;
                    $display("FAIL write: got data=%h ready=%b id=%0d, required data=%h ready=%b id=%0d",
                             o_data, o_ready, o_grant_id, e.data, 4'b0001 << e.id, e.id);
                end
            end
        end else if (o_ready !== 4'b0000 || o_data !== 8'h00) begin
            miscompares++;
            $display("FAIL idle_outputs: got ready=%b data=%h, required 0000/00", o_ready, o_data);
        end
        if (o_grant_vld && !prev_gv) glog.push_back(o_grant_id);
        prev_gv = o_grant_vld;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < N; k++) if (s_ready[k]) cnt[k]++;
        drive_data();
    endtask

    task automatic test_reset();
        clear_tb();
        i_valid = 4'b1111;
        i_rst = 1'b1; i_abort = 1'b0; i_full = 1'b0;
        tick();
        vectors++;
        if (o_grant_vld !== 1'b0 || o_wr_en !== 1'b0 || o_ready !== 4'b0 || o_data !== 8'h0 || o_grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got gv=%b we=%b rdy=%b data=%h id=%0d, required all 0",
                     o_grant_vld, o_wr_en, o_ready, o_data, o_grant_id);
        end
        i_valid = 4'b0000;
        reset_dut();
    endtask

    task automatic test_single();
        logic [9:0] pat;
        pat = 10'b1111011110;
        clear_tb();
        i_valid = 4'b0001;
        reset_dut();
        push_exp(0, 8'h10, 8);
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (s_wr_en !== pat[i]) begin
                miscompares++;
                $display("FAIL single_wr_en c%0d: got %b, required %b", i, s_wr_en, pat[i]);
            end
        end
        i_valid = 4'b0000;
        repeat (2) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_leftover: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        clear_tb();
        i_valid = 4'b1111;
        reset_dut();
        push_exp(0, 8'h10, 4); push_exp(1, 8'h20, 4); push_exp(2, 8'h30, 4);
        push_exp(3, 8'h40, 4); push_exp(0, 8'h14, 4);
        for (int i = 0; i < 25; i++) begin
            tick();
            vectors++;
            if (s_wr_en !== ((i % 5) != 0)) begin
                miscompares++;
                $display("FAIL rr_wr_en c%0d: got %b, required %b", i, s_wr_en, (i % 5) != 0);
            end
        end
        i_valid = 4'b0000;
        repeat (2) tick();
        vectors++;
        if (glog.size() != 5 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL rr_counts: got grants=%0d pending=%0d, required 5/0", glog.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                vectors++;
                if (glog[i] !== order[i]) begin
                    miscompares++;
                    $display("FAIL rr_order[%0d]: got %0d, required %0d", i, glog[i], order[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_tb();
        i_valid = 4'b0100;
        reset_dut();
        push_exp(2, 8'h30, 4);
        repeat (3) tick();
        i_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (s_wr_en !== 1'b0 || s_gv !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_full c%0d: got we=%b gv=%b, required 0/1", i, s_wr_en, s_gv);
            end
        end
        i_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (s_wr_en !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_resume %0d: got we=%b, required 1", i, s_wr_en);
            end
        end
        i_valid = 4'b0000;
        tick();
        vectors++;
        if (s_gv !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got gv=%b, required 0", s_gv);
        end
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_leftover: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_early_release();
        clear_tb();
        i_valid = 4'b0010;
        reset_dut();
        push_exp(1, 8'h20, 2); push_exp(3, 8'h40, 4);
        tick();
        i_valid = 4'b1011;
        repeat (2) tick();
        i_valid = 4'b1001;
        tick();
        vectors++;
        if (s_wr_en !== 1'b0 || s_gv !== 1'b1) begin
            miscompares++;
            $display("FAIL early_drop: got we=%b gv=%b, required 0/1", s_wr_en, s_gv);
        end
        tick();
        vectors++;
        if (s_gv !== 1'b0) begin
            miscompares++;
            $display("FAIL early_bubble: got gv=%b, required 0", s_gv);
        end
        tick();
        vectors++;
        if (s_gv !== 1'b1 || s_gid !== 2'd3) begin
            miscompares++;
            $display("FAIL early_next: got gv=%b id=%0d, required 1/3", s_gv, s_gid);
        end
        repeat (3) tick();
        i_valid = 4'b0000;
        repeat (2) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL early_leftover: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_abort();
        clear_tb();
        i_valid = 4'b0001;
        reset_dut();
        push_exp(0, 8'h10, 2); push_exp(1, 8'h20, 4); push_exp(0, 8'h12, 1);
        repeat (3) tick();
        i_abort = 1'b1;
        i_valid = 4'b0011;
        tick();
        vectors++;
        if (s_wr_en !== 1'b0 || s_gv !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_cycle: got we=%b gv=%b, required 0/1", s_wr_en, s_gv);
        end
        i_abort = 1'b0;
        tick();
        vectors++;
        if (s_gv !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got gv=%b, required 0", s_gv);
        end
        tick();
        vectors++;
        if (s_gv !== 1'b1 || s_gid !== 2'd1) begin
            miscompares++;
            $display("FAIL abort_next: got gv=%b id=%0d, required 1/1", s_gv, s_gid);
        end
        repeat (3) tick();
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        tick();
        vectors++;
        if (s_gv !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_in_idle: got gv=%b, required 0", s_gv);
        end
        tick();
        vectors++;
        if (s_gv !== 1'b1 || s_gid !== 2'd0) begin
            miscompares++;
            $display("FAIL abort_in_idle_next: got gv=%b id=%0d, required 1/0", s_gv, s_gid);
        end
        i_valid = 4'b0000;
        repeat (2) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL abort_leftover: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        clear_tb();
        i_valid = 4'b0011;
        reset_dut();
        push_exp(0, 8'h10, 4); push_exp(1, 8'h20, 1); push_exp(0, 8'h14, 1);
        repeat (7) tick();
        #2 i_rst = 1'b1;
        #1;
        vectors++;
        if (o_grant_vld !== 1'b0 || o_wr_en !== 1'b0 || o_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL async_reset: got gv=%b we=%b rdy=%b, required 0/0/0000", o_grant_vld, o_wr_en, o_ready);
        end
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        prev_gv = 1'b0;
        tick();
        vectors++;
        if (s_gv !== 1'b0) begin
            miscompares++;
            $display("FAIL async_post_idle: got gv=%b, required 0", s_gv);
        end
        tick();
        vectors++;
        if (s_gv !== 1'b1 || s_gid !== 2'd0) begin
            miscompares++;
            $display("FAIL async_post_grant: got gv=%b id=%0d, required 1/0", s_gv, s_gid);
        end
        i_valid = 4'b0000;
        repeat (2) tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL async_leftover: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_contention();
        logic [1:0] order [4];
        order = '{2'd1, 2'd3, 2'd1, 2'd3};
        clear_tb();
        i_valid = 4'b1010;
        reset_dut();
        push_exp(1, 8'h20, 4); push_exp(3, 8'h40, 4); push_exp(1, 8'h24, 4); push_exp(3, 8'h44, 4);
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (s_wr_en !== ((i % 5) != 0)) begin
                miscompares++;
                $display("FAIL cont_wr_en c%0d: got %b, required %b", i, s_wr_en, (i % 5) != 0);
            end
        end
        i_valid = 4'b0000;
        repeat (2) tick();
        vectors++;
        if (glog.size() != 4 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL cont_counts: got grants=%0d pending=%0d, required 4/0", glog.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (glog[i] !== order[i]) begin
                    miscompares++;
                    $display("FAIL cont_order[%0d]: got %0d, required %0d", i, glog[i], order[i]);
                end
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_valid = '0; i_full = 1'b0; i_abort = 1'b0; i_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_early_release();
        test_abort();
        test_async_reset();
        test_contention();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
